vga_timing_gen: RTL and testbench

Raster timing generator for the VGA output path: produces DrawX/DrawY pixel coordinates, the active-high `blank` display-enable, and active-low hsync/vsync for 640x480@60 Hz. It sits directly upstream of every sprite/renderer stage, such as the green_s renderer, which consumes `DrawX`, `DrawY` and `blank` and registers RGB one clock later. The sync outputs are therefore delayed by a configurable number of pixel clocks so they stay aligned with renderer RGB. The block also emits line/frame strobes and a free-running frame counter for animation and beat-step timing.

---
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60 VGA: pixel coordinates, display enable,
// delayed active-low syncs, line/frame strobes and a wrapping frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] x_nxt_s;
  logic [9:0] y_nxt_s;
  logic       x_wrap_s;
  logic       frame_wrap_s;
  logic       hs_raw_r;
  logic       vs_raw_r;

  // Next raster position; everything registered below is decoded from it.
  always_comb begin
    x_wrap_s     = (DrawX == H_LAST);
    frame_wrap_s = x_wrap_s && (DrawY == V_LAST);
    x_nxt_s      = DrawX;
    y_nxt_s      = DrawY;
    if (x_wrap_s) begin
      x_nxt_s = 10'd0;
      if (DrawY == V_LAST) begin
        y_nxt_s = 10'd0;
      end else begin
        y_nxt_s = DrawY + 10'd1;
      end
    end else begin
      x_nxt_s = DrawX + 10'd1;
      y_nxt_s = DrawY;
    end
  end

  // Coordinate, decode and strobe registers; reset parks at the last pixel of the frame.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank       <= 1'b0;
      hs_raw_r    <= 1'b1;
      vs_raw_r    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else if (pix_ce) begin
      DrawX       <= x_nxt_s;
      DrawY       <= y_nxt_s;
      blank       <= (x_nxt_s < H_VIS) && (y_nxt_s < V_VIS);
      hs_raw_r    <= !((x_nxt_s >= HS_FIRST) && (x_nxt_s <= HS_LAST));
      vs_raw_r    <= !((y_nxt_s >= VS_FIRST) && (y_nxt_s <= VS_LAST));
      line_start  <= x_wrap_s;
      frame_start <= frame_wrap_s;
      if (frame_wrap_s) begin
        frame_count <= frame_count + 8'd1;
      end else begin
        frame_count <= frame_count;
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs = hs_raw_r;
      assign vs = vs_raw_r;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe_r;
      logic [SYNC_DELAY-1:0] vs_pipe_r;

      // Sync alignment pipe: moves only on pixel advances so it tracks renderer RGB.
      always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
          hs_pipe_r <= '1;
          vs_pipe_r <= '1;
        end else if (pix_ce) begin
          for (int i = SYNC_DELAY - 1; i > 0; i--) begin
            hs_pipe_r[i] <= hs_pipe_r[i-1];
            vs_pipe_r[i] <= vs_pipe_r[i-1];
          end
          hs_pipe_r[0] <= hs_raw_r;
          vs_pipe_r[0] <= vs_raw_r;
        end else begin
          hs_pipe_r <= hs_pipe_r;
          vs_pipe_r <= vs_pipe_r;
        end
      end

      assign hs = hs_pipe_r[SYNC_DELAY-1];
      assign vs = vs_pipe_r[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing (delays 0/1/3), a short-frame
// variant for vsync/frame wrap, and a tiny variant for the 8-bit frame counter wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, reset_n_s, pix_ce, ce_s;

  logic [9:0] m_x, m_y, d0_x, d0_y, d3_x, d3_y, v_x, v_y, s_x, s_y;
  logic       m_blank, m_hs, m_vs, m_ls, m_fs;
  logic       d0_blank, d0_hs, d0_vs, d0_ls, d0_fs;
  logic       d3_blank, d3_hs, d3_vs, d3_ls, d3_fs;
  logic       v_blank, v_hs, v_vs, v_ls, v_fs;
  logic       s_blank, s_hs, s_vs, s_ls, s_fs;
  logic [7:0] m_fc, d0_fc, d3_fc, v_fc, s_fc;

  vga_timing_gen u_dut (
    .vga_clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .DrawX(m_x), .DrawY(m_y),
    .blank(m_blank), .hs(m_hs), .vs(m_vs), .line_start(m_ls), .frame_start(m_fs),
    .frame_count(m_fc));

  vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (
    .vga_clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .DrawX(d0_x), .DrawY(d0_y),
    .blank(d0_blank), .hs(d0_hs), .vs(d0_vs), .line_start(d0_ls), .frame_start(d0_fs),
    .frame_count(d0_fc));

  vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (
    .vga_clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .DrawX(d3_x), .DrawY(d3_y),
    .blank(d3_blank), .hs(d3_hs), .vs(d3_vs), .line_start(d3_ls), .frame_start(d3_fs),
    .frame_count(d3_fc));

  // 800 x 10 raster: vsync on lines 6..7
  vga_timing_gen #(.V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) u_v (
    .vga_clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .DrawX(v_x), .DrawY(v_y),
    .blank(v_blank), .hs(v_hs), .vs(v_vs), .line_start(v_ls), .frame_start(v_fs),
    .frame_count(v_fc));

  // 8 x 6 raster = 48 clocks per frame, own reset, always advancing
  vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_s (
    .vga_clk(clk), .reset_n(reset_n_s), .pix_ce(ce_s), .DrawX(s_x), .DrawY(s_y),
    .blank(s_blank), .hs(s_hs), .vs(s_vs), .line_start(s_ls), .frame_start(s_fs),
    .frame_count(s_fc));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int coord_err, hs1_cnt, hs0_cnt, hs3_cnt, hs1_first, hs0_first, hs3_first;
    int run, prev_x, hold_err, strobe_err, ls_cnt, hs_low;
    int prev_ls, prev_fs, vs_low, vs_first_x, vs_first_y, got_wrap, pvx, pvy, found;

    reset_n = 1'b0; reset_n_s = 1'b0; pix_ce = 1'b1; ce_s = 1'b1;
    repeat (3) tick();
    check_val("rst_x", m_x, 799);
    check_val("rst_y", m_y, 524);
    check_val("rst_blank", m_blank, 0);
    check_val("rst_hs", m_hs, 1);
    check_val("rst_vs", m_vs, 1);
    check_val("rst_ls", m_ls, 0);
    check_val("rst_fs", m_fs, 0);
    check_val("rst_fc", m_fc, 0);
    check_val("rst_d3_hs", d3_hs, 1);

    // Lines 0 and 1 at full rate
    reset_n = 1'b1; reset_n_s = 1'b1; cyc = -1;
    coord_err = 0; hs1_cnt = 0; hs0_cnt = 0; hs3_cnt = 0;
    hs1_first = -1; hs0_first = -1; hs3_first = -1;
    for (int n = 0; n < 1600; n++) begin
      tick();
      if (m_x != n % 800 || m_y != n / 800) coord_err++;
      if (n == 0) begin
        check_val("first_x", m_x, 0);
        check_val("first_y", m_y, 0);
        check_val("first_blank", m_blank, 1);
        check_val("first_ls", m_ls, 1);
        check_val("first_fs", m_fs, 1);
        check_val("first_fc", m_fc, 1);
      end
      if (n < 800) begin
        if (!m_hs)  begin hs1_cnt++; if (hs1_first < 0) hs1_first = m_x;  end
        if (!d0_hs) begin hs0_cnt++; if (hs0_first < 0) hs0_first = d0_x; end
        if (!d3_hs) begin hs3_cnt++; if (hs3_first < 0) hs3_first = d3_x; end
      end
      if (n == 639) check_val("blank_639", m_blank, 1);
      if (n == 640) check_val("blank_640", m_blank, 0);
      if (n == 799) check_val("ls_799", m_ls, 0);
      if (n == 800) begin
        check_val("l1_blank", m_blank, 1);
        check_val("l1_ls", m_ls, 1);
        check_val("l1_fs", m_fs, 0);
        check_val("l1_y", m_y, 1);
      end
    end
    check_val("coord_seq", coord_err, 0);
    check_val("hs1_width", hs1_cnt, 96);
    check_val("hs1_first_x", hs1_first, 657);
    check_val("hs0_width", hs0_cnt, 96);
    check_val("hs0_first_x", hs0_first, 656);
    check_val("hs3_width", hs3_cnt, 96);
    check_val("hs3_first_x", hs3_first, 659);

    // Line 2 with pix_ce toggling 1,0,1,0...
    run = -1; prev_x = m_x; hold_err = 0; strobe_err = 0; ls_cnt = 0; hs_low = 0;
    prev_ls = m_ls; prev_fs = m_fs;
    for (int k = 0; k < 1600; k++) begin
      pix_ce = (k % 2 == 0);
      tick();
      if (m_x != prev_x) begin
        if (run != -1 && run != 2) hold_err++;
        run = 1;
      end else if (run != -1) begin
        run++;
      end
      prev_x = m_x;
      if ((m_ls && prev_ls != 0) || (m_fs && prev_fs != 0)) strobe_err++;
      prev_ls = m_ls; prev_fs = m_fs;
      ls_cnt += m_ls;
      if (!m_hs) hs_low++;
    end
    check_val("ce_hold_2clk", hold_err, 0);
    check_val("ce_strobe_width", strobe_err, 0);
    check_val("ce_ls_count", ls_cnt, 1);
    check_val("ce_hs_width", hs_low, 192);

    // One full 8000-clock frame of the short raster
    pix_ce = 1'b1;
    vs_low = 0; vs_first_x = -1; vs_first_y = -1; got_wrap = 0; pvx = v_x; pvy = v_y;
    for (int k = 0; k < 8000; k++) begin
      tick();
      if (!v_vs) begin
        vs_low++;
        if (vs_first_x < 0) begin vs_first_x = v_x; vs_first_y = v_y; end
      end
      if (v_x == 0 && v_y == 0 && got_wrap == 0) begin
        got_wrap = 1;
        check_val("wrap_prev_x", pvx, 799);
        check_val("wrap_prev_y", pvy, 9);
        check_val("wrap_fs", v_fs, 1);
        check_val("wrap_fc", v_fc, 2);
      end
      pvx = v_x; pvy = v_y;
    end
    check_val("vs_width", vs_low, 1600);
    check_val("vs_first_x", vs_first_x, 1);
    check_val("vs_first_y", vs_first_y, 6);
    check_val("wrap_seen", got_wrap, 1);

    // Mid-frame reset with pix_ce low
    found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      tick();
      if (m_x == 300 && m_y == 13) found = 1;
    end
    check_val("reach_300_13", found, 1);
    pix_ce = 1'b0;
    tick();
    check_val("hold_x", m_x, 300);
    check_val("hold_ls", m_ls, 0);
    check_val("hold_blank", m_blank, 1);
    check_val("hold_fc", m_fc, 1);
    reset_n = 1'b0;
    tick();
    check_val("mrst_x", m_x, 799);
    check_val("mrst_y", m_y, 524);
    check_val("mrst_blank", m_blank, 0);
    check_val("mrst_fc", m_fc, 0);
    reset_n = 1'b1;
    tick();
    check_val("mrst_idle_x", m_x, 799);
    pix_ce = 1'b1;
    tick();
    check_val("mrst_adv_x", m_x, 0);
    check_val("mrst_adv_y", m_y, 0);
    check_val("mrst_adv_fs", m_fs, 1);
    check_val("mrst_adv_fc", m_fc, 1);

    // Tiny raster: frame 255 ends at clock 12239, counter wraps at 12240
    while (cyc < 12239) tick();
    check_val("s_fc_255", s_fc, 255);
    check_val("s_x_last", s_x, 7);
    check_val("s_y_last", s_y, 5);
    tick();
    check_val("s_fc_wrap", s_fc, 0);
    check_val("s_fs_wrap", s_fs, 1);
    check_val("s_x_wrap", s_x, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
